// File: rtl/timebase_counter_if.sv
// Bus bundle for timebase_counter: counter control/configuration inputs and the
// registered count/status outputs. master drives the controls, slave is the counter.
interface timebase_counter_if #(
   parameter int unsigned WIDTH = 8
);
   logic             enableIN;
   logic [WIDTH-1:0] topIN;
   logic             downIN;
   logic             loadIN;
   logic [WIDTH-1:0] loadValueIN;
   logic             oneShotIN;
   logic             startIN;
   logic [WIDTH-1:0] compareIN;
   logic [WIDTH-1:0] counterOUT;
   logic             overflowOUT;
   logic             busyOUT;
   logic             compareOUT;

   modport master (
      output enableIN, topIN, downIN, loadIN, loadValueIN, oneShotIN, startIN, compareIN,
      input  counterOUT, overflowOUT, busyOUT, compareOUT
   );

   modport slave (
      input  enableIN, topIN, downIN, loadIN, loadValueIN, oneShotIN, startIN, compareIN,
      output counterOUT, overflowOUT, busyOUT, compareOUT
   );
endinterface

// File: rtl/timebase_counter.sv
// Runtime-programmable up/down period counter with load, one-shot start/busy and
// terminal pulse. Define TIMEBASE_COUNTER_COMPARE_EN to enable the compare-match output.
module timebase_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clkIN,
   input  logic               resetIN,
   timebase_counter_if.slave  bus
);
   localparam int unsigned W = WIDTH;

   if (W < 1 || W > 32) begin : gWidthCheck
      $error("timebase_counter: WIDTH must be in 1..32");
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } stateT;

   stateT          state;
   logic [W-1:0]   countQ;
   logic           overflowQ;
   logic           busyQ;
   logic           compareQ;

   logic [W-1:0]   stepValue;
   logic           stepWrap;
   logic           idleOneShot;
   logic           startNow;
   logic           countNow;
   logic [W-1:0]   nextCount;
   logic           nextOverflow;

   // One count step in the current direction; >= lets a lowered topIN wrap at once.
   always_comb begin
      stepWrap  = 1'b0;
      stepValue = countQ;
      if (bus.downIN) begin
         stepWrap  = (countQ == '0);
         stepValue = stepWrap ? bus.topIN : countQ - W'(1);
      end else begin
         stepWrap  = (countQ >= bus.topIN);
         stepValue = stepWrap ? '0 : countQ + W'(1);
      end
   end

   // Next count value with load > start > count priority; a parked one-shot never counts.
   always_comb begin
      idleOneShot  = bus.oneShotIN && (state == IDLE);
      startNow     = idleOneShot && bus.startIN;
      countNow     = bus.enableIN && !idleOneShot;
      nextCount    = countQ;
      nextOverflow = 1'b0;
      if (bus.loadIN) begin
         nextCount = bus.loadValueIN;
      end else if (startNow) begin
         nextCount = bus.downIN ? bus.topIN : '0;
      end else if (countNow) begin
         nextCount    = stepValue;
         nextOverflow = stepWrap;
      end
   end

   // Count registers and one-shot FSM; busy tracks RUN on the same edge as the state.
   always_ff @(posedge clkIN) begin
      if (resetIN) begin
         state     <= IDLE;
         countQ    <= '0;
         overflowQ <= 1'b0;
         busyQ     <= 1'b0;
      end else begin
         countQ    <= nextCount;
         overflowQ <= nextOverflow;
         if (!bus.oneShotIN) begin
            state <= IDLE;
            busyQ <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.startIN) begin
                     state <= RUN;
                     busyQ <= 1'b1;
                  end
               end
               RUN: begin
                  if (!bus.loadIN && countNow && stepWrap) begin
                     state <= IDLE;
                     busyQ <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
                  busyQ <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef TIMEBASE_COUNTER_COMPARE_EN
   // Match against the value counterOUT is about to show, so both align.
   always_ff @(posedge clkIN) begin
      if (resetIN) begin
         compareQ <= 1'b0;
      end else begin
         compareQ <= (nextCount == bus.compareIN);
      end
   end
`else
   logic unusedCompare;
   assign unusedCompare = ^bus.compareIN;
   assign compareQ      = 1'b0;
`endif

   assign bus.counterOUT  = countQ;
   assign bus.overflowOUT = overflowQ;
   assign bus.busyOUT     = busyQ;
   assign bus.compareOUT  = compareQ;

endmodule

// File: tb/tb_timebase_counter.sv
// Self-checking bench for timebase_counter: directed scenarios plus randomized
// stimulus against a behavioural model of the counting rules.
module tb_timebase_counter;
   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   timebase_counter_if #(.WIDTH(W)) ifc ();

   timebase_counter #(.WIDTH(W)) dut (
      .clkIN  (clk),
      .resetIN(rst),
      .bus    (ifc)
   );

   always #5 clk = ~clk;

   // Behavioural model state
   int mCount;
   bit mOvf;
   bit mBusy;
   bit mRunning;
   bit mCmp;

   // Apply one clock edge of the counting rules to the model, using the current inputs.
   task automatic modelStep();
      int top;
      top = int'(ifc.topIN);
      if (rst) begin
         mCount = 0; mOvf = 0; mRunning = 0; mBusy = 0; mCmp = 0;
         return;
      end
      if (ifc.loadIN) begin
         mCount = int'(ifc.loadValueIN);
         mOvf   = 0;
         if (ifc.oneShotIN && !mRunning && ifc.startIN) mRunning = 1;
      end else if (ifc.oneShotIN && !mRunning && ifc.startIN) begin
         mCount   = ifc.downIN ? top : 0;
         mOvf     = 0;
         mRunning = 1;
      end else if (ifc.enableIN && (!ifc.oneShotIN || mRunning)) begin
         if (!ifc.downIN) begin
            if (mCount >= top) begin mCount = 0; mOvf = 1; end
            else begin mCount = mCount + 1; mOvf = 0; end
         end else begin
            if (mCount == 0) begin mCount = top; mOvf = 1; end
            else begin mCount = mCount - 1; mOvf = 0; end
         end
         if (mOvf && ifc.oneShotIN) mRunning = 0;
      end else begin
         mOvf = 0;
      end
      if (!ifc.oneShotIN) mRunning = 0;
      mBusy = mRunning;
`ifdef TIMEBASE_COUNTER_COMPARE_EN
      mCmp = (mCount == int'(ifc.compareIN));
`else
      mCmp = 0;
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   function automatic logic [W+2:0] dutVec();
      return {ifc.counterOUT, ifc.overflowOUT, ifc.busyOUT, ifc.compareOUT};
   endfunction

   function automatic logic [W+2:0] modelVec();
      return {W'(mCount), mOvf, mBusy, mCmp};
   endfunction

   task automatic setIdleInputs();
      ifc.enableIN = 1'b0; ifc.topIN = '0; ifc.downIN = 1'b0; ifc.loadIN = 1'b0;
      ifc.loadValueIN = '0; ifc.oneShotIN = 1'b0; ifc.startIN = 1'b0; ifc.compareIN = '1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      setIdleInputs();
      tick(); tick();
      checks++;
      if (dutVec() !== {W'(0), 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got=%h exp=%h", dutVec(), {W'(0), 3'b000});
      end
      rst = 1'b0;
   endtask

   task automatic test_free_run_up();
      ifc.topIN = W'(4); ifc.enableIN = 1'b1; ifc.downIN = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (ifc.counterOUT !== W'((i + 1) % 5) || ifc.overflowOUT !== ((i + 1) % 5 == 0)) begin
            errors++;
            $display("FAIL free_run_up cyc=%0d got=%0d/%b exp=%0d/%b", i, ifc.counterOUT,
                     ifc.overflowOUT, (i + 1) % 5, ((i + 1) % 5 == 0));
         end
         checks++;
         if (dutVec() !== modelVec()) begin
            errors++;
            $display("FAIL free_run_up_model cyc=%0d got=%h exp=%h", i, dutVec(), modelVec());
         end
      end
   endtask

   task automatic test_down_enable();
      int expCount;
      ifc.topIN = W'(3); ifc.downIN = 1'b1; ifc.loadIN = 1'b1; ifc.loadValueIN = W'(3);
      tick();
      ifc.loadIN = 1'b0;
      checks++;
      if (ifc.counterOUT !== W'(3)) begin
         errors++;
         $display("FAIL down_load got=%0d exp=3", ifc.counterOUT);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         expCount = (i < 3) ? 2 - i : 3;
         checks++;
         if (ifc.counterOUT !== W'(expCount) || ifc.overflowOUT !== (i == 3)) begin
            errors++;
            $display("FAIL down_seq cyc=%0d got=%0d/%b exp=%0d/%b", i, ifc.counterOUT,
                     ifc.overflowOUT, expCount, (i == 3));
         end
      end
      ifc.enableIN = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (ifc.counterOUT !== W'(3) || ifc.overflowOUT !== 1'b0) begin
            errors++;
            $display("FAIL enable_hold cyc=%0d got=%0d/%b exp=3/0", i, ifc.counterOUT,
                     ifc.overflowOUT);
         end
      end
      ifc.enableIN = 1'b1;
      tick();
      ifc.downIN = 1'b0;
      tick();
      checks++;
      if (dutVec() !== modelVec() || ifc.counterOUT !== W'(3)) begin
         errors++;
         $display("FAIL up_to_three got=%h exp=%h", dutVec(), modelVec());
      end
      ifc.topIN = W'(1);
      tick();
      checks++;
      if (ifc.counterOUT !== W'(0) || ifc.overflowOUT !== 1'b1) begin
         errors++;
         $display("FAIL top_lowered got=%0d/%b exp=0/1", ifc.counterOUT, ifc.overflowOUT);
      end
   endtask

   task automatic test_load_priority();
      ifc.topIN = W'(10); ifc.downIN = 1'b0; ifc.enableIN = 1'b1;
      ifc.loadIN = 1'b1; ifc.loadValueIN = W'(10);
      tick();
      ifc.loadValueIN = W'(200);
      tick();
      ifc.loadIN = 1'b0;
      checks++;
      if (ifc.counterOUT !== W'(200) || ifc.overflowOUT !== 1'b0) begin
         errors++;
         $display("FAIL load_priority got=%0d/%b exp=200/0", ifc.counterOUT, ifc.overflowOUT);
      end
      tick();
      checks++;
      if (ifc.counterOUT !== W'(0) || ifc.overflowOUT !== 1'b1) begin
         errors++;
         $display("FAIL load_above_top got=%0d/%b exp=0/1", ifc.counterOUT, ifc.overflowOUT);
      end
   endtask

   task automatic test_one_shot();
      logic [2:0] gotCob;
      ifc.oneShotIN = 1'b1; ifc.topIN = W'(2); ifc.downIN = 1'b0; ifc.enableIN = 1'b1;
      tick(); tick();
      checks++;
      if (ifc.counterOUT !== W'(0) || ifc.busyOUT !== 1'b0) begin
         errors++;
         $display("FAIL one_shot_idle got=%0d/%b exp=0/0", ifc.counterOUT, ifc.busyOUT);
      end
      ifc.startIN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         // A second start lands mid-RUN and must be ignored
         ifc.startIN = (i == 1);
         gotCob = {ifc.counterOUT[1:0], ifc.busyOUT};
         checks++;
         if (i < 3 && (ifc.counterOUT !== W'(i) || ifc.busyOUT !== 1'b1 ||
                       ifc.overflowOUT !== 1'b0)) begin
            errors++;
            $display("FAIL one_shot_run cyc=%0d got=%0d/%b/%b exp=%0d/1/0", i, ifc.counterOUT,
                     ifc.busyOUT, ifc.overflowOUT, i);
         end else if (i >= 3 && (ifc.counterOUT !== W'(0) || ifc.busyOUT !== 1'b0 ||
                                 ifc.overflowOUT !== (i == 3))) begin
            errors++;
            $display("FAIL one_shot_end cyc=%0d got=%0d/%b/%b exp=0/0/%b", i, ifc.counterOUT,
                     ifc.busyOUT, ifc.overflowOUT, (i == 3));
         end
         checks++;
         if (dutVec() !== modelVec()) begin
            errors++;
            $display("FAIL one_shot_model cyc=%0d got=%h exp=%h cob=%b", i, dutVec(),
                     modelVec(), gotCob);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      ifc.oneShotIN = 1'b1; ifc.topIN = W'(5); ifc.enableIN = 1'b1; ifc.startIN = 1'b1;
      tick();
      ifc.startIN = 1'b0;
      tick();
      checks++;
      if (ifc.counterOUT !== W'(1) || ifc.busyOUT !== 1'b1) begin
         errors++;
         $display("FAIL mid_run_setup got=%0d/%b exp=1/1", ifc.counterOUT, ifc.busyOUT);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (dutVec() !== {W'(0), 3'b000}) begin
         errors++;
         $display("FAIL reset_mid_run got=%h exp=%h", dutVec(), {W'(0), 3'b000});
      end
      // Back in IDLE the enabled counter must stay parked
      tick(); tick();
      checks++;
      if (ifc.counterOUT !== W'(0) || ifc.busyOUT !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got=%0d/%b exp=0/0", ifc.counterOUT, ifc.busyOUT);
      end
   endtask

   task automatic test_compare();
      rst = 1'b1;
      setIdleInputs();
      tick();
      rst = 1'b0;
      ifc.topIN = W'(5); ifc.compareIN = W'(3); ifc.enableIN = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         checks++;
`ifdef TIMEBASE_COUNTER_COMPARE_EN
         if (ifc.compareOUT !== (ifc.counterOUT == W'(3))) begin
`else
         if (ifc.compareOUT !== 1'b0) begin
`endif
            errors++;
            $display("FAIL compare cyc=%0d got=%b count=%0d", i, ifc.compareOUT, ifc.counterOUT);
         end
         checks++;
         if (dutVec() !== modelVec()) begin
            errors++;
            $display("FAIL compare_model cyc=%0d got=%h exp=%h", i, dutVec(), modelVec());
         end
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      for (int i = 0; i < 600; i++) begin
         rst             = ($urandom_range(0, 63) == 0);
         ifc.loadIN      = ($urandom_range(0, 15) == 0);
         ifc.loadValueIN = W'($urandom_range(0, 255));
         ifc.startIN     = ($urandom_range(0, 7) == 0);
         ifc.enableIN    = ($urandom_range(0, 3) != 0);
         ifc.downIN      = ($urandom_range(0, 5) == 0) ? ~ifc.downIN : ifc.downIN;
         if ($urandom_range(0, 31) == 0) ifc.oneShotIN = ~ifc.oneShotIN;
         if ($urandom_range(0, 19) == 0) ifc.topIN = W'($urandom_range(0, 12));
         if ($urandom_range(0, 19) == 0) ifc.compareIN = W'($urandom_range(0, 12));
         tick();
         checks++;
         if (dutVec() !== modelVec()) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL random cyc=%0d got=%h exp=%h", i, dutVec(), modelVec());
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      setIdleInputs();
      test_reset();
      test_free_run_up();
      test_down_enable();
      test_load_priority();
      test_one_shot();
      test_reset_mid_run();
      test_compare();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
